vae_layer_sequencer: RTL and testbench
======================================

// Module: vae_layer_sequencer
// PURPOSE
//  Time-multiplexed controller for the VAE inference path: drives one shared fixed-point MAC
//  (multiply + add units) through encoder (9->4), sampling and decoder (2->9) layers.
//  Generates weight/bias ROM addresses, operand selects, accumulator strobes and activation
//  selects (softplus/sigmoid); accepts a frame via valid/ready, signals result via valid/ready.
// PARAMETERS
//  N_ENC_IN   9   encoder inputs per neuron
//  M_ENC_OUT  4   encoder neurons (odd indices 1,3 = variance -> softplus)
//  N_DEC_IN   2   decoder inputs (latent size)
//  M_DEC_OUT  9   decoder neurons (all -> sigmoid)
//  MAC_LAT    2   MAC pipeline latency in cycles (>=1)
//  AW         6   weight address width (must hold N_ENC_IN*M_ENC_OUT+N_DEC_IN*M_DEC_OUT)
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    reset rst, synchronous, active-high
//  in_valid   in   1    new input frame x available
//  in_ready   out  1    sequencer idle, frame accepted on in_valid&in_ready
//  out_valid  out  1    all 9 sigmoid results written to result buffer
//  out_ready  in   1    consumer took result
//  w_addr     out  AW   weight ROM address
//  b_addr     out  4    bias ROM address (enc 0..3, dec 4..12)
//  op_sel     out  1    MAC operand source: 0 = input buffer x, 1 = latent z
//  op_idx     out  4    operand index into selected source
//  acc_load   out  1    load accumulator with bias (clears previous sum)
//  mac_en     out  1    accumulate w*operand this cycle
//  res_wr     out  1    write activated accumulator to result slot res_idx
//  res_idx    out  4    result slot index (enc 0..3, dec 0..8)
//  act_sel    out  2    0 none, 1 softplus, 2 sigmoid (valid with res_wr)
//  samp_start out  1    one-cycle pulse: sampling block consumes enc results, PRNG steps
//  samp_done  in   1    sampling finished, z valid
//  busy       out  1    high in any state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; in_ready=0 in reset cycle, 1 from first IDLE cycle; all other outputs 0.
//  States: IDLE, BIAS, MAC, DRAIN, WRITE, SAMPLE, DONE; layer flag ENC/DEC.
//  IDLE: in_ready=1; on in_valid -> BIAS, layer=ENC, neuron j=0.
//  BIAS: acc_load=1, b_addr=j (ENC) or M_ENC_OUT+j (DEC); -> MAC, i=0.
//  MAC: mac_en=1, w_addr=j*N+i (ENC) or N_ENC_IN*M_ENC_OUT+j*N_DEC_IN+i (DEC);
//   op_sel=layer, op_idx=i; one product per cycle; after i=N-1 -> DRAIN.
//  DRAIN: MAC_LAT cycles, all strobes low; -> WRITE.
//  WRITE: res_wr=1, res_idx=j; act_sel ENC: softplus if j odd else none; DEC: sigmoid.
//   If j<M-1: j++ -> BIAS. Else ENC -> SAMPLE; DEC -> DONE.
//  SAMPLE: samp_start pulses on first cycle only; wait for samp_done (held any length,
//   no timeout); samp_done in same cycle as samp_start is legal -> BIAS, layer=DEC, j=0.
//  DONE: out_valid=1 held until out_ready; -> IDLE. in_ready stays 0 in DONE (no overlap).
//  Cycle counts (MAC_LAT=2): enc neuron 1+9+2+1=13, encoder 52; dec neuron 1+2+2+1=6,
//   decoder 54; accept->out_valid = 52 + sample cycles + 54 + 1.
//  Strobes acc_load/mac_en/res_wr mutually exclusive; addresses 0 when their strobe is low.
//  rst mid-frame: next cycle IDLE, all strobes and out_valid low, counters zero; partial
//   results discarded; samp_done arriving outside SAMPLE ignored.
//  in_valid outside IDLE ignored; out_ready outside DONE ignored.
// STRUCTURE
//  Shared header vae_defs.vh: state encodings, ACT_NONE/SOFTPLUS/SIGMOID codes, Q4.27
//   sign-magnitude format constants (BITSIZE=32, FRAC=27), layer sizes, ROM base offsets.
//  Sub-module vae_idx_counter: nested i/j counter with load, inc, last_i/last_j flags;
//   instantiated once, reloaded with layer limits at layer switch.
//  No arithmetic inside sequencer; datapath and ROMs live outside.
// TESTING
//  1 Reset then in_valid=1 -> in_ready drops next cycle; first acc_load with b_addr=0,
//    then 9 mac_en with w_addr 0..8, op_idx 0..8, op_sel=0.
//  2 Full frame, samp_done 3 cycles after samp_start -> res_wr acts: none,softplus,none,
//    softplus then 9x sigmoid; out_valid exactly at cycle 52+4+54+1 after accept.
//  3 Decoder neuron 8 -> b_addr=12, w_addr 52,53, op_sel=1, op_idx 0,1.
//  4 out_ready low 10 cycles in DONE -> out_valid held, no strobes, in_valid ignored.
//  5 rst asserted during MAC of enc neuron 2 -> next cycle IDLE, all outputs 0,
//    in_ready=1; new frame restarts at b_addr=0.
//  6 samp_done pulse during ENC MAC and same cycle as samp_start -> first ignored,
//    second accepted, decoder starts next cycle.

Source files
------------

// File: rtl/vae_layer_sequencer_pkg.sv
// Shared constants for the VAE layer sequencer: state codes, activation codes,
// layer sizes, ROM base offsets and the fixed-point format used by the datapath.
package vae_layer_sequencer_pkg;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_BIAS   = 3'd1;
  localparam logic [STATE_W-1:0] ST_MAC    = 3'd2;
  localparam logic [STATE_W-1:0] ST_DRAIN  = 3'd3;
  localparam logic [STATE_W-1:0] ST_WRITE  = 3'd4;
  localparam logic [STATE_W-1:0] ST_SAMPLE = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd6;

  localparam int ACT_W = 2;
  localparam logic [ACT_W-1:0] ACT_NONE     = 2'd0;
  localparam logic [ACT_W-1:0] ACT_SOFTPLUS = 2'd1;
  localparam logic [ACT_W-1:0] ACT_SIGMOID  = 2'd2;

  // Index / bias-address width shared by op_idx, res_idx and b_addr
  localparam int IDX_W = 4;

  // Default layer geometry
  localparam int ENC_N_IN  = 9;
  localparam int ENC_M_OUT = 4;
  localparam int DEC_N_IN  = 2;
  localparam int DEC_M_OUT = 9;

  // ROM layout: encoder weights/biases first, decoder directly after
  localparam int ENC_W_BASE = 0;
  localparam int DEC_W_BASE = ENC_N_IN * ENC_M_OUT;
  localparam int ENC_B_BASE = 0;
  localparam int DEC_B_BASE = ENC_M_OUT;

  // Q4.27 sign-magnitude datapath format
  localparam int Q_BITSIZE = 32;
  localparam int Q_FRAC    = 27;

  typedef enum logic {
    LAYER_ENC = 1'b0,
    LAYER_DEC = 1'b1
  } layer_e;

  // Encoder odd neurons are variances (softplus), even are means (linear);
  // every decoder neuron is a sigmoid output pixel.
  function automatic logic [ACT_W-1:0] act_code(layer_e layer, logic j_odd);
    if (layer == LAYER_DEC) return ACT_SIGMOID;
    return j_odd ? ACT_SOFTPLUS : ACT_NONE;
  endfunction

endpackage

// File: rtl/vae_layer_sequencer_if.sv
// Handshake, ROM-address and MAC-control bundle between the sequencer (master)
// and the datapath/host side (slave).
interface vae_layer_sequencer_if #(
  parameter int AW = 6
);
  import vae_layer_sequencer_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    w_addr;
  logic [IDX_W-1:0] b_addr;
  logic             op_sel;
  logic [IDX_W-1:0] op_idx;
  logic             acc_load;
  logic             mac_en;
  logic             res_wr;
  logic [IDX_W-1:0] res_idx;
  logic [ACT_W-1:0] act_sel;
  logic             samp_start;
  logic             samp_done;
  logic             busy;

  modport master (
    input  in_valid, out_ready, samp_done,
    output in_ready, out_valid, w_addr, b_addr, op_sel, op_idx,
           acc_load, mac_en, res_wr, res_idx, act_sel, samp_start, busy
  );

  modport slave (
    output in_valid, out_ready, samp_done,
    input  in_ready, out_valid, w_addr, b_addr, op_sel, op_idx,
           acc_load, mac_en, res_wr, res_idx, act_sel, samp_start, busy
  );

endinterface

// File: rtl/vae_layer_sequencer_idx_counter.sv
// Nested input (i) / neuron (j) counter. load_i restarts both at zero and latches
// the per-layer last-index limits; the last_* flags compare against those limits.
module vae_layer_sequencer_idx_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] n_last_i,
  input  logic [W-1:0] m_last_i,
  input  logic         clr_i_i,
  input  logic         inc_i_i,
  input  logic         inc_j_i,
  output logic [W-1:0] i_o,
  output logic [W-1:0] j_o,
  output logic         last_i_o,
  output logic         last_j_o
);

  logic [W-1:0] i_q, i_d;
  logic [W-1:0] j_q, j_d;
  logic [W-1:0] n_last_q, n_last_d;
  logic [W-1:0] m_last_q, m_last_d;

  // Next-state: layer reload wins over per-neuron clear/increment
  always_comb begin
    i_d      = i_q;
    j_d      = j_q;
    n_last_d = n_last_q;
    m_last_d = m_last_q;
    if (load_i) begin
      i_d      = '0;
      j_d      = '0;
      n_last_d = n_last_i;
      m_last_d = m_last_i;
    end else begin
      if (clr_i_i)      i_d = '0;
      else if (inc_i_i) i_d = i_q + 1'b1;
      if (inc_j_i)      j_d = j_q + 1'b1;
    end
  end

  // Counter and limit registers
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q      <= '0;
      j_q      <= '0;
      n_last_q <= '0;
      m_last_q <= '0;
    end else begin
      i_q      <= i_d;
      j_q      <= j_d;
      n_last_q <= n_last_d;
      m_last_q <= m_last_d;
    end
  end

  assign i_o      = i_q;
  assign j_o      = j_q;
  assign last_i_o = (i_q == n_last_q);
  assign last_j_o = (j_q == m_last_q);

endmodule

// File: rtl/vae_layer_sequencer.sv
// Time-multiplexed controller for the VAE inference path. Steps one shared MAC
// through the encoder, hands off to the sampling block, then runs the decoder.
// Weight and bias addresses are running pointers: both ROMs are laid out so the
// sequencer walks them strictly in order, which keeps multipliers out of here.
module vae_layer_sequencer #(
  parameter int N_ENC_IN  = 9,
  parameter int M_ENC_OUT = 4,
  parameter int N_DEC_IN  = 2,
  parameter int M_DEC_OUT = 9,
  parameter int MAC_LAT   = 2,
  parameter int AW        = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  vae_layer_sequencer_if.master bus
);
  import vae_layer_sequencer_pkg::*;

  localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT - 1);

  logic [STATE_W-1:0] state_q, state_d;
  layer_e             layer_q, layer_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [AW-1:0]      w_ptr_q, w_ptr_d;
  logic [IDX_W-1:0]   b_ptr_q, b_ptr_d;
  logic               samp_first_q, samp_first_d;

  logic               cnt_load;
  logic [IDX_W-1:0]   cnt_n_last;
  logic [IDX_W-1:0]   cnt_m_last;
  logic               cnt_clr_i;
  logic               cnt_inc_i;
  logic               cnt_inc_j;
  logic [IDX_W-1:0]   cnt_i;
  logic [IDX_W-1:0]   cnt_j;
  logic               cnt_last_i;
  logic               cnt_last_j;

  vae_layer_sequencer_idx_counter #(
    .W (IDX_W)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .load_i   (cnt_load),
    .n_last_i (cnt_n_last),
    .m_last_i (cnt_m_last),
    .clr_i_i  (cnt_clr_i),
    .inc_i_i  (cnt_inc_i),
    .inc_j_i  (cnt_inc_j),
    .i_o      (cnt_i),
    .j_o      (cnt_j),
    .last_i_o (cnt_last_i),
    .last_j_o (cnt_last_j)
  );

  // FSM transitions, pointer advance and counter control
  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    drain_d      = drain_q;
    w_ptr_d      = w_ptr_q;
    b_ptr_d      = b_ptr_q;
    samp_first_d = 1'b0;
    cnt_load     = 1'b0;
    cnt_n_last   = '0;
    cnt_m_last   = '0;
    cnt_clr_i    = 1'b0;
    cnt_inc_i    = 1'b0;
    cnt_inc_j    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d    = ST_BIAS;
          layer_d    = LAYER_ENC;
          w_ptr_d    = '0;
          b_ptr_d    = '0;
          cnt_load   = 1'b1;
          cnt_n_last = IDX_W'(N_ENC_IN - 1);
          cnt_m_last = IDX_W'(M_ENC_OUT - 1);
        end
      end
      ST_BIAS: begin
        state_d   = ST_MAC;
        cnt_clr_i = 1'b1;
      end
      ST_MAC: begin
        w_ptr_d = w_ptr_q + 1'b1;
        if (cnt_last_i) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          cnt_inc_i = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = ST_WRITE;
        else                       drain_d = drain_q + 1'b1;
      end
      ST_WRITE: begin
        b_ptr_d = b_ptr_q + 1'b1;
        if (!cnt_last_j) begin
          cnt_inc_j = 1'b1;
          state_d   = ST_BIAS;
        end else if (layer_q == LAYER_ENC) begin
          state_d      = ST_SAMPLE;
          samp_first_d = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SAMPLE: begin
        if (bus.samp_done) begin
          state_d    = ST_BIAS;
          layer_d    = LAYER_DEC;
          cnt_load   = 1'b1;
          cnt_n_last = IDX_W'(N_DEC_IN - 1);
          cnt_m_last = IDX_W'(M_DEC_OUT - 1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      layer_q      <= LAYER_ENC;
      drain_q      <= '0;
      w_ptr_q      <= '0;
      b_ptr_q      <= '0;
      samp_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      drain_q      <= drain_d;
      w_ptr_q      <= w_ptr_d;
      b_ptr_q      <= b_ptr_d;
      samp_first_q <= samp_first_d;
    end
  end

  // Output decode: every address/index is forced to zero outside its strobe
  always_comb begin
    bus.in_ready   = (state_q == ST_IDLE) && !rst;
    bus.busy       = (state_q != ST_IDLE);
    bus.out_valid  = (state_q == ST_DONE);
    bus.acc_load   = (state_q == ST_BIAS);
    bus.b_addr     = '0;
    bus.mac_en     = (state_q == ST_MAC);
    bus.w_addr     = '0;
    bus.op_sel     = 1'b0;
    bus.op_idx     = '0;
    bus.res_wr     = (state_q == ST_WRITE);
    bus.res_idx    = '0;
    bus.act_sel    = ACT_NONE;
    bus.samp_start = (state_q == ST_SAMPLE) && samp_first_q;
    if (state_q == ST_BIAS) begin
      bus.b_addr = b_ptr_q;
    end
    if (state_q == ST_MAC) begin
      bus.w_addr = w_ptr_q;
      bus.op_sel = (layer_q == LAYER_DEC);
      bus.op_idx = cnt_i;
    end
    if (state_q == ST_WRITE) begin
      bus.res_idx = cnt_j;
      bus.act_sel = act_code(layer_q, cnt_j[0]);
    end
  end

endmodule

// File: tb/tb_vae_layer_sequencer.sv
// Directed bench for vae_layer_sequencer: reset, first encoder neuron, full frame
// timing and activation order, DONE hold, samp_done filtering, reset mid-frame.
`timescale 1ns/1ps
module tb_vae_layer_sequencer;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  vae_layer_sequencer_if #(.AW(6)) bus ();

  vae_layer_sequencer #(
    .N_ENC_IN  (9),
    .M_ENC_OUT (4),
    .N_DEC_IN  (2),
    .M_DEC_OUT (9),
    .MAC_LAT   (2),
    .AW        (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.samp_done = 1'b0;
    tick(); tick();
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
    n_cmp++;
    if ({bus.busy, bus.out_valid, bus.acc_load, bus.mac_en, bus.res_wr, bus.samp_start} !== 6'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b want 000000",
        {bus.busy, bus.out_valid, bus.acc_load, bus.mac_en, bus.res_wr, bus.samp_start});
    end
    n_cmp++;
    if ({bus.w_addr, bus.b_addr, bus.op_idx, bus.res_idx, bus.act_sel, bus.op_sel} !== 21'b0) begin
      n_err++; $display("FAIL reset_addrs: got w=%0d b=%0d op=%0d res=%0d act=%0d", bus.w_addr, bus.b_addr, bus.op_idx, bus.res_idx, bus.act_sel);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_first_neuron();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL accept_in_ready: got %0b want 0", bus.in_ready); end
    n_cmp++;
    if ({bus.acc_load, bus.b_addr} !== {1'b1, 4'd0}) begin
      n_err++; $display("FAIL first_bias: got load=%0b b=%0d want load=1 b=0", bus.acc_load, bus.b_addr);
    end
    for (int k = 0; k < 9; k++) begin
      tick();
      n_cmp++;
      if ({bus.mac_en, bus.op_sel, bus.w_addr, bus.op_idx} !== {1'b1, 1'b0, 6'(k), 4'(k)}) begin
        n_err++; $display("FAIL first_mac%0d: got en=%0b sel=%0b w=%0d op=%0d want 1 0 %0d %0d",
          k, bus.mac_en, bus.op_sel, bus.w_addr, bus.op_idx, k, k);
      end
    end
    tick();
    n_cmp++;
    if (bus.mac_en !== 1'b0) begin n_err++; $display("FAIL first_drain: got mac_en=%0b want 0", bus.mac_en); end
    pulse_reset();
  endtask

  task automatic test_full_frame();
    int c, ss, ov, nacc, nmac, nwr, viol;
    logic [1:0] act_exp [0:12];
    logic [3:0] idx_exp;
    act_exp = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    c = 1; ss = -1; ov = -1; nacc = 0; nmac = 0; nwr = 0; viol = 0;
    while (ov < 0 && c < 300) begin
      if (bus.acc_load === 1'b1) begin
        n_cmp++;
        if (bus.b_addr !== 4'(nacc)) begin n_err++; $display("FAIL bias_addr%0d: got %0d want %0d", nacc, bus.b_addr, nacc); end
        nacc++;
      end
      if (bus.mac_en === 1'b1) begin
        idx_exp = (nmac < 36) ? 4'(nmac % 9) : 4'((nmac - 36) % 2);
        n_cmp++;
        if ({bus.w_addr, bus.op_sel, bus.op_idx} !== {6'(nmac), (nmac >= 36), idx_exp}) begin
          n_err++; $display("FAIL mac%0d: got w=%0d sel=%0b op=%0d want w=%0d sel=%0b op=%0d",
            nmac, bus.w_addr, bus.op_sel, bus.op_idx, nmac, (nmac >= 36), idx_exp);
        end
        nmac++;
      end
      if (bus.res_wr === 1'b1 && nwr < 13) begin
        idx_exp = (nwr < 4) ? 4'(nwr) : 4'(nwr - 4);
        n_cmp++;
        if ({bus.act_sel, bus.res_idx} !== {act_exp[nwr], idx_exp}) begin
          n_err++; $display("FAIL write%0d: got act=%0d idx=%0d want act=%0d idx=%0d",
            nwr, bus.act_sel, bus.res_idx, act_exp[nwr], idx_exp);
        end
        nwr++;
      end
      if ((32'(bus.acc_load) + 32'(bus.mac_en) + 32'(bus.res_wr)) > 1) viol++;
      if (!bus.acc_load && bus.b_addr !== 4'd0) viol++;
      if (!bus.mac_en && (bus.w_addr !== 6'd0 || bus.op_idx !== 4'd0 || bus.op_sel !== 1'b0)) viol++;
      if (!bus.res_wr && (bus.res_idx !== 4'd0 || bus.act_sel !== 2'd0)) viol++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) viol++;
      if (bus.samp_start === 1'b1) ss = c;
      bus.samp_done = (ss >= 0 && c == ss + 3);
      if (bus.out_valid === 1'b1) ov = c;
      else begin tick(); c++; end
    end
    bus.samp_done = 1'b0;
    n_cmp++;
    if (ov !== 111) begin n_err++; $display("FAIL frame_out_valid_cycle: got %0d want 111", ov); end
    n_cmp++;
    if (ss !== 53) begin n_err++; $display("FAIL samp_start_cycle: got %0d want 53", ss); end
    n_cmp++;
    if ({nacc, nmac, nwr} !== {32'd13, 32'd54, 32'd13}) begin
      n_err++; $display("FAIL strobe_counts: got acc=%0d mac=%0d wr=%0d want 13 54 13", nacc, nmac, nwr);
    end
    n_cmp++;
    if (viol !== 0) begin n_err++; $display("FAIL strobe_rules: got %0d violations want 0", viol); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      n_err++; $display("FAIL frame_release: got ov/rdy/busy=%b want 010", {bus.out_valid, bus.in_ready, bus.busy});
    end
  endtask

  task automatic test_done_hold();
    int c, ov;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    c = 1; ov = -1;
    while (ov < 0 && c < 300) begin
      if (bus.out_valid === 1'b1) ov = c;
      else begin bus.samp_done = bus.samp_start; tick(); c++; end
    end
    bus.samp_done = 1'b0;
    n_cmp++;
    if (ov !== 108) begin n_err++; $display("FAIL fast_sample_out_valid_cycle: got %0d want 108", ov); end
    bus.in_valid = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.acc_load, bus.mac_en, bus.res_wr, bus.samp_start} !== 6'b100000) begin
        n_err++; $display("FAIL done_hold%0d: got %b want 100000", k,
          {bus.out_valid, bus.in_ready, bus.acc_load, bus.mac_en, bus.res_wr, bus.samp_start});
      end
      if (k < 10) tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.busy, bus.acc_load} !== 4'b0100) begin
      n_err++; $display("FAIL done_release: got ov/rdy/busy/load=%b want 0100",
        {bus.out_valid, bus.in_ready, bus.busy, bus.acc_load});
    end
  endtask

  task automatic test_samp_done_filter();
    int c, ov;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    c = 1; ov = -1;
    while (ov < 0 && c < 300) begin
      if (c == 6) begin
        n_cmp++;
        if ({bus.mac_en, bus.w_addr} !== {1'b1, 6'd4}) begin
          n_err++; $display("FAIL early_done_ignored: got en=%0b w=%0d want en=1 w=4", bus.mac_en, bus.w_addr);
        end
      end
      if (c == 53) begin
        n_cmp++;
        if (bus.samp_start !== 1'b1) begin n_err++; $display("FAIL samp_start_at_53: got %0b want 1", bus.samp_start); end
      end
      if (c == 54) begin
        n_cmp++;
        if ({bus.acc_load, bus.b_addr} !== {1'b1, 4'd4}) begin
          n_err++; $display("FAIL dec_start: got load=%0b b=%0d want load=1 b=4", bus.acc_load, bus.b_addr);
        end
      end
      if (bus.out_valid === 1'b1) ov = c;
      else begin bus.samp_done = (c == 5) || bus.samp_start; tick(); c++; end
    end
    bus.samp_done = 1'b0;
    n_cmp++;
    if (ov !== 108) begin n_err++; $display("FAIL same_cycle_done_out_valid: got %0d want 108", ov); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 1; k < 30; k++) tick();
    n_cmp++;
    if ({bus.mac_en, bus.w_addr, bus.op_idx} !== {1'b1, 6'd20, 4'd2}) begin
      n_err++; $display("FAIL enc2_mac: got en=%0b w=%0d op=%0d want 1 20 2", bus.mac_en, bus.w_addr, bus.op_idx);
    end
    pulse_reset();
    n_cmp++;
    if ({bus.in_ready, bus.busy, bus.out_valid, bus.acc_load, bus.mac_en, bus.res_wr, bus.samp_start} !== 7'b1000000) begin
      n_err++; $display("FAIL mid_reset_ctrl: got %b want 1000000",
        {bus.in_ready, bus.busy, bus.out_valid, bus.acc_load, bus.mac_en, bus.res_wr, bus.samp_start});
    end
    n_cmp++;
    if ({bus.w_addr, bus.b_addr, bus.op_idx, bus.res_idx, bus.act_sel, bus.op_sel} !== 21'b0) begin
      n_err++; $display("FAIL mid_reset_addrs: got w=%0d b=%0d op=%0d", bus.w_addr, bus.b_addr, bus.op_idx);
    end
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if ({bus.acc_load, bus.b_addr} !== {1'b1, 4'd0}) begin
      n_err++; $display("FAIL restart_bias: got load=%0b b=%0d want 1 0", bus.acc_load, bus.b_addr);
    end
    tick();
    n_cmp++;
    if ({bus.mac_en, bus.op_sel, bus.w_addr, bus.op_idx} !== {1'b1, 1'b0, 6'd0, 4'd0}) begin
      n_err++; $display("FAIL restart_mac: got en=%0b sel=%0b w=%0d op=%0d want 1 0 0 0",
        bus.mac_en, bus.op_sel, bus.w_addr, bus.op_idx);
    end
    pulse_reset();
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.samp_done = 1'b0;
    test_reset();
    test_first_neuron();
    test_full_frame();
    test_done_hold();
    test_samp_done_filter();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
